// File: rtl/cpu_pkg.sv
// Shared definitions for tiny_cpu_core: opcodes, FSM state encoding
// and instruction field offsets. Instruction layout MSB first: op|rd|rs|imm.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic int op_lsb(input int rsel_w, input int data_w);
    return 2 * rsel_w + data_w;
  endfunction

  function automatic int rd_lsb(input int rsel_w, input int data_w);
    return rsel_w + data_w;
  endfunction

  function automatic int rs_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for tiny_cpu_core.
// Ports: op_i, a_i (rd), b_i (rs) -> res_o, c_o, z_o, n_o, flags_we_o.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              z_o,
  output logic              n_o,
  output logic              flags_we_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum        = '0;
    res_o      = '0;
    c_o        = 1'b0;
    flags_we_o = 1'b0;
    unique case (op_i)
      OP_MOV: begin
        res_o      = b_i;
        flags_we_o = 1'b1;
      end
      OP_ADD: begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        res_o      = sum[DATA_W-1:0];
        c_o        = sum[DATA_W];
        flags_we_o = 1'b1;
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        sum        = {1'b0, a_i} - {1'b0, b_i};
        res_o      = sum[DATA_W-1:0];
        c_o        = sum[DATA_W];
        flags_we_o = 1'b1;
      end
      OP_AND: begin
        res_o      = a_i & b_i;
        flags_we_o = 1'b1;
      end
      OP_OR: begin
        res_o      = a_i | b_i;
        flags_we_o = 1'b1;
      end
      OP_XOR: begin
        res_o      = a_i ^ b_i;
        flags_we_o = 1'b1;
      end
      OP_NOT: begin
        res_o      = ~b_i;
        flags_we_o = 1'b1;
      end
      OP_SHL: begin
        res_o      = {b_i[DATA_W-2:0], 1'b0};
        c_o        = b_i[DATA_W-1];
        flags_we_o = 1'b1;
      end
      OP_SHR: begin
        res_o      = {1'b0, b_i[DATA_W-1:1]};
        c_o        = b_i[0];
        flags_we_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign z_o = (res_o == '0);
  assign n_o = res_o[DATA_W-1];

endmodule

// File: rtl/tiny_cpu_core.sv
// Multi-cycle accumulator/register CPU: FETCH/WAIT/EXEC over a sync ROM.
// Ports: clk, rst, run, step, prog_addr/prog_data (ROM), out_val/out_valid,
// pc, flags {N,C,Z}, state_o, halted.
module tiny_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 4,
  parameter  int NREGS   = 4,
  localparam int RSEL_W  = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2 * RSEL_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  out_val,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         flags,
  output logic [2:0]         state_o,
  output logic               halted
);

  localparam int OP_L = op_lsb(RSEL_W, DATA_W);
  localparam int RD_L = rd_lsb(RSEL_W, DATA_W);
  localparam int RS_L = rs_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   prog_addr_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [2:0]          flags_q;
  logic [DATA_W-1:0]   out_val_q;
  logic                out_valid_q;

  logic [3:0]          op;
  logic [RSEL_W-1:0]   rd, rs;
  logic [DATA_W-1:0]   imm, rd_val, rs_val;
  logic [DATA_W-1:0]   alu_res, wdata;
  logic                alu_c, alu_z, alu_n, alu_fwe;
  logic                rf_we, jump, out_en, halt_op, exec;

  assign op     = ir_q[OP_L +: 4];
  assign rd     = ir_q[RD_L +: RSEL_W];
  assign rs     = ir_q[RS_L +: RSEL_W];
  assign imm    = ir_q[DATA_W-1:0];
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];
  assign exec   = (state_q == S_EXEC);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (op),
    .a_i       (rd_val),
    .b_i       (rs_val),
    .res_o     (alu_res),
    .c_o       (alu_c),
    .z_o       (alu_z),
    .n_o       (alu_n),
    .flags_we_o(alu_fwe)
  );

  always_comb begin
    rf_we   = 1'b0;
    wdata   = alu_res;
    jump    = 1'b0;
    out_en  = 1'b0;
    halt_op = 1'b0;
    unique case (op)
      OP_LDI: begin
        rf_we = 1'b1;
        wdata = imm;
      end
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: rf_we = 1'b1;
      OP_JMP:  jump    = 1'b1;
      OP_JZ:   jump    = flags_q[0];
      OP_JC:   jump    = flags_q[1];
      OP_OUT:  out_en  = 1'b1;
      OP_HALT: halt_op = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE:  if (run || step) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_EXEC;
      S_EXEC: begin
        pc_d = jump ? imm[ADDR_W-1:0] : pc_q + PC_ONE;
        if (halt_op)  state_d = S_HALT;
        else if (run) state_d = S_FETCH;
        else          state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      prog_addr_q <= '0;
      ir_q        <= '0;
      flags_q     <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= exec && out_en;
      if (state_q == S_FETCH) prog_addr_q <= pc_q;
      if (state_q == S_WAIT)  ir_q <= prog_data;
      if (exec && rf_we)      regs_q[rd] <= wdata;
      if (exec && alu_fwe)    flags_q <= {alu_n, alu_c, alu_z};
      if (exec && out_en)     out_val_q <= rs_val;
    end
  end

  assign prog_addr = prog_addr_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign out_val   = out_val_q;
  assign out_valid = out_valid_q;
  assign state_o   = state_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Self-checking bench for tiny_cpu_core (default parameters).
// Instruction-level reference model plus directed scenarios.
module tb_tiny_cpu_core;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic [3:0]  prog_addr, pc;
  logic [15:0] prog_data;
  logic [7:0]  out_val;
  logic        out_valid, halted;
  logic [2:0]  flags, state_o;

  logic [15:0] rom [16];
  int checks = 0;
  int errors = 0;

  logic [7:0] m_r [4];
  int m_pc, m_out;
  bit m_n, m_c, m_z, m_halt, m_outv;

  always #5 clk = ~clk;

  assign prog_data = rom[prog_addr];

  tiny_cpu_core dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .out_val  (out_val),
    .out_valid(out_valid),
    .pc       (pc),
    .flags    (flags),
    .state_o  (state_o),
    .halted   (halted)
  );

  function automatic logic [15:0] enc(input int op, input int rd,
                                      input int rs, input int imm);
    return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 0; m_out = 0;
    m_n = 0; m_c = 0; m_z = 0; m_halt = 0; m_outv = 0;
  endtask

  task automatic model_step();
    int op, rd, rs, imm, a, b, r, nxt;
    bit wr;
    op  = int'(rom[m_pc][15:12]);
    rd  = int'(rom[m_pc][11:10]);
    rs  = int'(rom[m_pc][9:8]);
    imm = int'(rom[m_pc][7:0]);
    a = int'(m_r[rd]); b = int'(m_r[rs]);
    wr = 0; r = 0; m_outv = 0;
    nxt = (m_pc + 1) % 16;
    case (op)
      1:  m_r[rd] = 8'(imm);
      2:  begin r = b; m_c = 0; wr = 1; end
      3:  begin r = a + b; m_c = (r > 255); r = r % 256; wr = 1; end
      4:  begin m_c = (a < b); r = (a - b + 256) % 256; wr = 1; end
      5:  begin r = a & b; m_c = 0; wr = 1; end
      6:  begin r = a | b; m_c = 0; wr = 1; end
      7:  begin r = a ^ b; m_c = 0; wr = 1; end
      8:  begin r = 255 - b; m_c = 0; wr = 1; end
      9:  begin m_c = (b >= 128); r = (b * 2) % 256; wr = 1; end
      10: begin m_c = (b % 2 == 1); r = b / 2; wr = 1; end
      11: nxt = imm % 16;
      12: if (m_z) nxt = imm % 16;
      13: if (m_c) nxt = imm % 16;
      14: begin m_out = b; m_outv = 1; end
      15: m_halt = 1;
      default: ;
    endcase
    if (wr) begin
      m_r[rd] = 8'(r);
      m_z = (r == 0);
      m_n = (r >= 128);
    end
    m_pc = nxt;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  // Pulse step from an IDLE negedge; return at the next IDLE/HALT negedge.
  task automatic step_one(output bit to);
    to = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (state_o == 3'd0 || state_o == 3'd4) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    fill_nop();
    rom[0] = enc(1, 1, 0, 8'h55);
    rom[1] = enc(14, 0, 1, 0);
    rom[2] = enc(15, 0, 0, 0);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    #1;
    checks++;
    if ({pc, prog_addr, flags, out_val, out_valid, halted, state_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h addr=%h fl=%b ov=%h ovld=%b h=%b st=%0d expected all 0",
               pc, prog_addr, flags, out_val, out_valid, halted, state_o);
    end
    do_reset();
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state_o == 3'd3) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_reach_exec: state=%0d expected 3", state_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || pc !== 4'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: state=%0d pc=%h expected 0 0", state_o, pc);
    end
    rom[0] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    checks++;
    if (halted !== 1'b1 || out_val !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort_write: halted=%b out_val=%h expected 1 00",
               halted, out_val);
    end
    run = 1'b0;
  endtask

  task automatic test_add_program();
    int n, pulses;
    fill_nop();
    rom[0] = enc(1, 0, 0, 8'hF0);
    rom[1] = enc(1, 1, 0, 8'h20);
    rom[2] = enc(3, 0, 1, 0);
    rom[3] = enc(14, 0, 0, 0);
    rom[4] = enc(15, 0, 0, 0);
    do_reset();
    run = 1'b1;
    n = 0; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) pulses++;
      if (halted) break;
    end
    checks++;
    if (n - 1 !== 15 || halted !== 1'b1) begin
      errors++;
      $display("FAIL add_halt_latency: clocks=%0d halted=%b expected 15 1", n - 1, halted);
    end
    checks++;
    if (out_val !== 8'h10) begin
      errors++;
      $display("FAIL add_out_val: got %h expected 10", out_val);
    end
    checks++;
    if (flags !== 3'b010) begin
      errors++;
      $display("FAIL add_flags: got %b expected 010", flags);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL add_out_pulses: got %0d expected 1", pulses);
    end
    run = 1'b0;
  endtask

  task automatic test_jz();
    bit to;
    for (int v = 0; v < 2; v++) begin
      fill_nop();
      rom[0] = enc(1, 0, 0, 7);
      rom[1] = enc(1, 1, 0, (v == 0) ? 7 : 6);
      rom[2] = enc(4, 0, 1, 0);
      rom[3] = enc(12, 0, 0, 8'h0A);
      do_reset();
      for (int s = 0; s < 3; s++) step_one(to);
      checks++;
      if (to || flags !== ((v == 0) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL jz_sub_flags%0d: got %b to=%b", v, flags, to);
      end
      step_one(to);
      checks++;
      if (to || pc !== ((v == 0) ? 4'hA : 4'h4)) begin
        errors++;
        $display("FAIL jz_pc%0d: got %h expected %h", v, pc,
                 (v == 0) ? 4'hA : 4'h4);
      end
    end
  endtask

  task automatic test_step();
    int execs;
    fill_nop();
    for (int i = 0; i < 8; i++) rom[i] = enc(1, i % 4, 0, i + 1);
    do_reset();
    execs = 0;
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      if (state_o == 3'd3) execs++;
      step = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (state_o == 3'd3) execs++;
      end
      checks++;
      if (pc !== 4'(k + 1) || state_o !== 3'd0) begin
        errors++;
        $display("FAIL step_pc%0d: pc=%h st=%0d expected %h 0", k, pc, state_o, k + 1);
      end
    end
    checks++;
    if (execs !== 4) begin
      errors++;
      $display("FAIL step_retired: got %0d expected 4", execs);
    end
  endtask

  task automatic test_pc_wrap();
    int fetches, last, cyc;
    bit wrapped, saw15;
    fill_nop();
    do_reset();
    run = 1'b1;
    fetches = 0; last = 0; wrapped = 0; saw15 = 0;
    for (cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (pc == 4'hF) saw15 = 1;
      if (saw15 && pc == 4'h0) wrapped = 1;
      if (state_o == 3'd2) begin
        if (prog_addr !== 4'(fetches % 16) ||
            (fetches > 0 && cyc - last != 3)) begin
          errors++;
          $display("FAIL wrap_fetch%0d: addr=%h gap=%0d expected %h 3",
                   fetches, prog_addr, cyc - last, fetches % 16);
        end
        checks++;
        last = cyc;
        fetches++;
      end
    end
    checks++;
    if (!wrapped || fetches < 18) begin
      errors++;
      $display("FAIL wrap_seen: wrapped=%b fetches=%0d expected 1 >=18", wrapped, fetches);
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift_mov();
    bit to;
    fill_nop();
    rom[0]  = enc(1, 0, 0, 8'h81);
    rom[1]  = enc(9, 1, 0, 0);
    rom[2]  = enc(14, 0, 1, 0);
    rom[3]  = enc(1, 0, 0, 8'h01);
    rom[4]  = enc(10, 1, 0, 0);
    rom[5]  = enc(14, 0, 1, 0);
    rom[6]  = enc(1, 2, 0, 8'h5A);
    rom[7]  = enc(1, 3, 0, 8'hFF);
    rom[8]  = enc(3, 3, 3, 0);
    rom[9]  = enc(2, 2, 2, 0);
    rom[10] = enc(14, 0, 2, 0);
    rom[11] = enc(15, 0, 0, 0);
    do_reset();
    for (int s = 1; s <= 12; s++) begin
      step_one(to);
      case (s)
        2, 5, 9, 10: begin
          logic [2:0] ef;
          ef = (s == 2) ? 3'b010 : (s == 5) ? 3'b011 :
               (s == 9) ? 3'b110 : 3'b000;
          checks++;
          if (to || flags !== ef) begin
            errors++;
            $display("FAIL shift_flags_s%0d: got %b expected %b", s, flags, ef);
          end
        end
        3, 6, 11: begin
          logic [7:0] ev;
          ev = (s == 3) ? 8'h02 : (s == 6) ? 8'h00 : 8'h5A;
          checks++;
          if (to || out_valid !== 1'b1 || out_val !== ev) begin
            errors++;
            $display("FAIL shift_out_s%0d: vld=%b val=%h expected 1 %h",
                     s, out_valid, out_val, ev);
          end
        end
        12: begin
          checks++;
          if (halted !== 1'b1) begin
            errors++;
            $display("FAIL shift_halt: halted=%b expected 1", halted);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic rand_prog();
    int op;
    for (int i = 0; i < 16; i++) begin
      op = int'($urandom_range(0, 15));
      if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
      rom[i] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_random_step();
    bit to;
    for (int p = 0; p < 5; p++) begin
      rand_prog();
      do_reset();
      for (int s = 0; s < 24; s++) begin
        step_one(to);
        model_step();
        checks++;
        if (to || pc !== 4'(m_pc) || flags !== {m_n, m_c, m_z} ||
            halted !== m_halt || out_valid !== m_outv ||
            (m_outv && out_val !== 8'(m_out))) begin
          errors++;
          $display("FAIL rand_step p%0d s%0d: pc=%h fl=%b h=%b ov=%b/%h expected %h %b %b %b/%h",
                   p, s, pc, flags, halted, out_valid, out_val,
                   4'(m_pc), {m_n, m_c, m_z}, m_halt, m_outv, 8'(m_out));
        end
        if (m_halt || to) break;
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int got_q[$];
    int cnt, ninst;
    bit done;
    for (int p = 0; p < 4; p++) begin
      rand_prog();
      do_reset();
      exp_q.delete();
      got_q.delete();
      ninst = 0;
      while (ninst < 30 && !m_halt) begin
        model_step();
        ninst++;
        if (m_outv) exp_q.push_back(m_out);
      end
      run = 1'b1;
      cnt = 0; done = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (out_valid) got_q.push_back(int'(out_val));
        if (halted) begin done = 1; break; end
        if (state_o == 3'd3) begin
          cnt++;
          if (cnt == ninst) run = 1'b0;
        end else if (state_o == 3'd0 && cnt == ninst) begin
          done = 1;
          break;
        end
      end
      run = 1'b0;
      checks++;
      if (!done || got_q.size() != exp_q.size() || pc !== 4'(m_pc) ||
          flags !== {m_n, m_c, m_z} || halted !== m_halt) begin
        errors++;
        $display("FAIL b2b_final p%0d: done=%b outs=%0d pc=%h fl=%b h=%b expected outs=%0d pc=%h fl=%b h=%b",
                 p, done, got_q.size(), pc, flags, halted, exp_q.size(),
                 4'(m_pc), {m_n, m_c, m_z}, m_halt);
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (got_q[k] != exp_q[k]) begin
            errors++;
            $display("FAIL b2b_out p%0d #%0d: got %h expected %h",
                     p, k, got_q[k], exp_q[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    fill_nop();
    test_reset();
    test_add_program();
    test_jz();
    test_step();
    test_pc_wrap();
    test_shift_mov();
    test_random_step();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
